// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   ALUCtrl operation encoding. ALU control decode and the execute-stage ALU
//   both use this package, so these values must not change.
//   Codes not listed here (000, 101, 111) execute as ADD.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALUCTRL_W = 3;

    typedef logic [ALUCTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALUCTRL_ADD = 3'b001;
    localparam alu_ctrl_t ALUCTRL_SUB = 3'b010;
    localparam alu_ctrl_t ALUCTRL_AND = 3'b011;
    localparam alu_ctrl_t ALUCTRL_OR  = 3'b100;
    localparam alu_ctrl_t ALUCTRL_MUL = 3'b110;

endpackage

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Operand/result handshake bundle of the execute-stage ALU.
//   Upstream side : valid_i, ready_o, ALUCtrl_i, src1_i, src2_i
//   Downstream    : valid_o, ready_i, result_o, zero_o
//   Status        : busy_o (multiply in progress)
//   Modport slave is the ALU, modport master is the stage that drives it.
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int XLEN = 32
) ();
    import alu_pkg::*;

    logic            valid_i;
    logic            ready_o;
    alu_ctrl_t       ALUCtrl_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            busy_o;

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, busy_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, busy_o
    );

endinterface

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier producing the low XLEN bits of a*b.
//   One multiplier bit is consumed per clock; the run takes XLEN clocks.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     abort        cancel a run in progress (wins over start)
//     start        capture a and b and begin a run
//     a, b         operands
//     done         high in the last cycle of a run; product is final then
//     product      accumulator after the step taken at the next edge
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;

    // product is the accumulator value after the current step, so the
    // parent can register the final result on the same edge as the last step.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(XLEN);
        end else if (running) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                running <= 1'b0;
            end
        end
    end

    // Datapath registers carry no reset; they are only observed while running.
    always_ff @(posedge clk) begin
        if (start && !abort) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU between the ID/EX operand latch and EX/MEM.
//   ADD/SUB/AND/OR complete in one cycle; MUL uses seq_multiplier and takes
//   XLEN cycles during which no new op is accepted.
//   Ports:
//     clk_i      clock, rising edge
//     rst_n_i    asynchronous active-low reset
//     flush_i    synchronous flush: aborts MUL, drops a held result
//     bus        alu_exec_unit_if.slave (valid/ready in, valid/ready out,
//                ALUCtrl_i, src1_i, src2_i, result_o, zero_o, busy_o)
//   result_o is held until valid_o && ready_i; zero_o feeds the beq decision
//   and is only meaningful while valid_o is high.
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    alu_exec_unit_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t          state;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic [XLEN-1:0] alu_value;

    function automatic logic [XLEN-1:0] alu_compute(
        input alu_ctrl_t       code,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (code)
            ALUCTRL_SUB: r = a + ~b + XLEN'(1);
            ALUCTRL_AND: r = a & b;
            ALUCTRL_OR:  r = a | b;
            default:     r = a + b;
        endcase
        return r;
    endfunction

    // A held result blocks new ops unless it leaves in this same cycle.
    assign bus.ready_o = (state == S_IDLE) && (!bus.valid_o || bus.ready_i);
    assign accept      = bus.valid_i && bus.ready_o;
    assign mul_start   = accept && !flush_i && (bus.ALUCtrl_i == ALUCTRL_MUL);
    assign alu_value   = alu_compute(bus.ALUCtrl_i, bus.src1_i, bus.src2_i);

    seq_multiplier #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .abort   (flush_i),
        .start   (mul_start),
        .a       (bus.src1_i),
        .b       (bus.src2_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            bus.valid_o  <= 1'b0;
            bus.result_o <= '0;
            bus.zero_o   <= 1'b0;
            bus.busy_o   <= 1'b0;
        end else if (flush_i) begin
            // result_o/zero_o intentionally keep their stale values.
            state       <= S_IDLE;
            bus.valid_o <= 1'b0;
            bus.busy_o  <= 1'b0;
        end else begin
            if (bus.valid_o && bus.ready_i) begin
                bus.valid_o <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.ALUCtrl_i == ALUCTRL_MUL) begin
                            state      <= S_MUL;
                            bus.busy_o <= 1'b1;
                        end else begin
                            bus.result_o <= alu_value;
                            bus.zero_o   <= (alu_value == '0);
                            bus.valid_o  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state        <= S_IDLE;
                        bus.busy_o   <= 1'b0;
                        bus.result_o <= mul_product;
                        bus.zero_o   <= (mul_product == '0);
                        bus.valid_o  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed scenarios with literal expectations followed by randomized
//   traffic, all mirrored by a transaction-level reference model that is
//   compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: cycles left on a multiply, output register.
    int          m_mul_left;
    logic        m_valid;
    logic        m_rdy;
    logic [31:0] m_result;
    logic [31:0] m_prod;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
        case (code)
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd6:    return a * b;
            default: return a + b;
        endcase
    endfunction

    // Reference model: advances on each rising edge using the inputs seen there.
    initial begin
        m_mul_left = 0;
        m_valid    = 1'b0;
        m_result   = '0;
        m_prod     = '0;
        m_rdy      = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mul_left = 0;
                m_valid    = 1'b0;
                m_result   = '0;
            end else begin
                m_rdy = (m_mul_left == 0) && (!m_valid || bus.ready_i);
                if (flush) begin
                    m_mul_left = 0;
                    m_valid    = 1'b0;
                end else begin
                    if (m_valid && bus.ready_i) m_valid = 1'b0;
                    if (m_mul_left > 0) begin
                        m_mul_left--;
                        if (m_mul_left == 0) begin
                            m_result = m_prod;
                            m_valid  = 1'b1;
                        end
                    end else if (bus.valid_i && m_rdy) begin
                        if (bus.ALUCtrl_i == 3'd6) begin
                            m_mul_left = XLEN;
                            m_prod     = ref_op(3'd6, bus.src1_i, bus.src2_i);
                        end else begin
                            m_result = ref_op(bus.ALUCtrl_i, bus.src1_i, bus.src2_i);
                            m_valid  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("valid_o", {31'd0, bus.valid_o}, {31'd0, m_valid});
            check("busy_o", {31'd0, bus.busy_o}, {31'd0, (m_mul_left > 0)});
            check("result_o", bus.result_o, m_result);
            check("ready_o", {31'd0, bus.ready_o},
                  {31'd0, ((m_mul_left == 0) && (!m_valid || bus.ready_i))});
            if (m_valid) check("zero_o", {31'd0, bus.zero_o}, {31'd0, (m_result == '0)});
        end
    end

    task automatic drive(input logic v, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b);
        bus.valid_i   = v;
        bus.ALUCtrl_i = code;
        bus.src1_i    = a;
        bus.src2_i    = b;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        bus.ready_i = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset valid_o", {31'd0, bus.valid_o}, 32'd0);
        check("reset result_o", bus.result_o, 32'd0);
        check("reset zero_o", {31'd0, bus.zero_o}, 32'd0);
        check("reset busy_o", {31'd0, bus.busy_o}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // ADD 5+7
        drive(1'b1, ALUCTRL_ADD, 32'd5, 32'd7);
        step(); idle();
        check("add valid", {31'd0, bus.valid_o}, 32'd1);
        check("add result", bus.result_o, 32'd12);
        check("add zero", {31'd0, bus.zero_o}, 32'd0);
        step();

        // SUB 9-9, then SUB 0-1 back to back
        drive(1'b1, ALUCTRL_SUB, 32'd9, 32'd9);
        step();
        check("sub zero result", bus.result_o, 32'd0);
        check("sub zero flag", {31'd0, bus.zero_o}, 32'd1);
        drive(1'b1, ALUCTRL_SUB, 32'd0, 32'd1);
        step(); idle();
        check("sub wrap result", bus.result_o, 32'hFFFF_FFFF);
        check("sub wrap zero", {31'd0, bus.zero_o}, 32'd0);
        check("sub wrap valid", {31'd0, bus.valid_o}, 32'd1);
        step();

        // MUL 0xFFFFFFFF*3 with a competing op offered while busy
        drive(1'b1, ALUCTRL_MUL, 32'hFFFF_FFFF, 32'd3);
        step();
        drive(1'b1, ALUCTRL_ADD, 32'd1, 32'd1);
        for (int i = 0; i < XLEN; i++) begin
            check("mul busy", {31'd0, bus.busy_o}, 32'd1);
            check("mul ready", {31'd0, bus.ready_o}, 32'd0);
            if (i == XLEN - 1) idle();
            step();
        end
        check("mul valid", {31'd0, bus.valid_o}, 32'd1);
        check("mul result", bus.result_o, 32'hFFFF_FFFD);
        check("mul busy end", {31'd0, bus.busy_o}, 32'd0);
        step();

        // MUL 0x1234*0
        drive(1'b1, ALUCTRL_MUL, 32'h1234, 32'd0);
        step(); idle();
        repeat (XLEN - 1) step();
        check("mul0 not early", {31'd0, bus.valid_o}, 32'd0);
        step();
        check("mul0 result", bus.result_o, 32'd0);
        check("mul0 zero", {31'd0, bus.zero_o}, 32'd1);
        step();

        // Output hold under back-pressure, then no-bubble handoff
        bus.ready_i = 1'b0;
        drive(1'b1, ALUCTRL_ADD, 32'd1, 32'd1);
        step(); idle();
        step();
        check("hold valid", {31'd0, bus.valid_o}, 32'd1);
        check("hold result", bus.result_o, 32'd2);
        check("hold ready_o", {31'd0, bus.ready_o}, 32'd0);
        drive(1'b1, ALUCTRL_AND, 32'hF0, 32'h3C);
        bus.ready_i = 1'b1;
        #1;
        check("handoff ready_o", {31'd0, bus.ready_o}, 32'd1);
        step(); idle();
        check("handoff valid", {31'd0, bus.valid_o}, 32'd1);
        check("handoff result", bus.result_o, 32'h30);
        step();
        check("handoff drained", {31'd0, bus.valid_o}, 32'd0);

        // Reset in the middle of a MUL
        drive(1'b1, ALUCTRL_MUL, 32'h1111, 32'h2222);
        step(); idle();
        repeat (9) step();
        #1 rst_n = 1'b0;
        #1;
        check("rst mid-mul busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst mid-mul valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst mid-mul result", bus.result_o, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        drive(1'b1, ALUCTRL_ADD, 32'd2, 32'd3);
        step(); idle();
        check("post-rst add", bus.result_o, 32'd5);
        repeat (40) step();
        check("no stale mul", {31'd0, bus.valid_o}, 32'd0);

        // Flush during MUL, then flush together with an offered op
        drive(1'b1, ALUCTRL_MUL, 32'd7, 32'd9);
        step(); idle();
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", {31'd0, bus.busy_o}, 32'd0);
        check("flush valid", {31'd0, bus.valid_o}, 32'd0);
        check("flush stale result", bus.result_o, 32'd5);
        flush = 1'b1;
        drive(1'b1, ALUCTRL_ADD, 32'd1, 32'd2);
        step();
        flush = 1'b0; idle();
        check("flush drops accept", {31'd0, bus.valid_o}, 32'd0);
        drive(1'b1, ALUCTRL_OR, 32'h1, 32'h2);
        step();
        check("or result", bus.result_o, 32'h3);
        drive(1'b1, 3'b111, 32'd4, 32'd4);
        step(); idle();
        check("code 111 as add", bus.result_o, 32'd8);
        step();

        // Randomized traffic checked by the model
        repeat (3000) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  pick_operand(), pick_operand());
            bus.ready_i = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            step();
        end
        idle();
        flush       = 1'b0;
        bus.ready_i = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
